// File: rtl/pipe_ctrl_carrier.sv
// pipe_ctrl_carrier: pipelined control registers plus stall, flush and forwarding hazard logic
module pipe_ctrl_carrier #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_EX,
    input  logic [1:0]       id_MEM,
    input  logic [1:0]       id_WB,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    output logic             ex_ALUSrc,
    output logic             ex_RegDst,
    output logic [2:0]       ex_ALUOp,
    output logic             ex_br_taken,
    output logic             mem_MemWrite,
    output logic             mem_MemRead,
    output logic             wb_MemtoReg,
    output logic             wb_RegWrite,
    output logic [4:0]       wb_dst,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic       idex_memwrite, idex_memread, idex_memtoreg, idex_regwrite, idex_branch;
    logic [4:0] idex_rs, idex_rt, idex_rd;
    logic       mem_memtoreg, mem_regwrite;
    logic [4:0] mem_dst;
    logic       lu, bubble_id;

    assign ex_br_taken = idex_branch & ex_zero;
    assign lu          = idex_memread && idex_rt != 5'd0 && (idex_rt == id_rs || idex_rt == id_rt);
    assign bubble_id   = lu | ex_br_taken;
    assign pc_write    = ex_br_taken | ~lu;
    assign ifid_write  = ex_br_taken | ~lu;
    assign ifid_flush  = ex_br_taken | (id_jump & ~lu);

    assign fwd_a = (mem_regwrite && mem_dst != 5'd0 && mem_dst == idex_rs) ? 2'b10 :
                   (wb_RegWrite && wb_dst != 5'd0 && wb_dst == idex_rs) ? 2'b01 : 2'b00;
    assign fwd_b = (mem_regwrite && mem_dst != 5'd0 && mem_dst == idex_rt) ? 2'b10 :
                   (wb_RegWrite && wb_dst != 5'd0 && wb_dst == idex_rt) ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            {ex_ALUSrc, ex_RegDst, ex_ALUOp} <= '0;
            {idex_memwrite, idex_memread, idex_memtoreg, idex_regwrite, idex_branch} <= '0;
            {idex_rs, idex_rt, idex_rd} <= '0;
            {mem_MemWrite, mem_MemRead, mem_memtoreg, mem_regwrite, mem_dst} <= '0;
            {wb_MemtoReg, wb_RegWrite, wb_dst} <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            {wb_MemtoReg, wb_RegWrite, wb_dst} <= {mem_memtoreg, mem_regwrite, mem_dst};
            {mem_MemWrite, mem_MemRead, mem_memtoreg, mem_regwrite} <=
                {idex_memwrite, idex_memread, idex_memtoreg, idex_regwrite};
            mem_dst <= ex_RegDst ? idex_rd : idex_rt;
            {ex_ALUSrc, ex_RegDst, ex_ALUOp} <= bubble_id ? 5'd0 : id_EX;
            {idex_memwrite, idex_memread} <= bubble_id ? 2'd0 : id_MEM;
            {idex_memtoreg, idex_regwrite} <= bubble_id ? 2'd0 : id_WB;
            idex_branch <= bubble_id ? 1'b0 : id_branch;
            {idex_rs, idex_rt, idex_rd} <= bubble_id ? 15'd0 : {id_rs, id_rt, id_rd};
            stall_cnt <= stall_cnt + CNT_W'(lu & ~ex_br_taken & ~&stall_cnt);
            flush_cnt <= flush_cnt + CNT_W'(ifid_flush & ~&flush_cnt);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_carrier.sv
// tb_pipe_ctrl_carrier: directed vector table plus reset and counter saturation sequences
module tb_pipe_ctrl_carrier;
    logic        clk = 1'b0, rst = 1'b0;
    logic [4:0]  id_EX, id_rs, id_rt, id_rd;
    logic [1:0]  id_MEM, id_WB;
    logic        id_branch, id_jump, ex_zero;
    logic        ex_ALUSrc, ex_RegDst, ex_br_taken, mem_MemWrite, mem_MemRead, wb_MemtoReg, wb_RegWrite;
    logic [2:0]  ex_ALUOp;
    logic [4:0]  wb_dst;
    logic [1:0]  fwd_a, fwd_b;
    logic        pc_write, ifid_write, ifid_flush;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_alusrc, s_regdst, s_br, s_mw, s_mr, s_mtr, s_rw, s_pcw, s_ifw, s_fl;
    logic [2:0]  s_aluop;
    logic [4:0]  s_dst;
    logic [1:0]  s_fa, s_fb;
    logic [3:0]  s_stall, s_flush;

    pipe_ctrl_carrier dut (
        .clk(clk), .rst(rst), .id_EX(id_EX), .id_MEM(id_MEM), .id_WB(id_WB),
        .id_branch(id_branch), .id_jump(id_jump), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_zero(ex_zero), .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_ALUOp(ex_ALUOp),
        .ex_br_taken(ex_br_taken), .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl_carrier #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_EX(id_EX), .id_MEM(id_MEM), .id_WB(id_WB),
        .id_branch(id_branch), .id_jump(id_jump), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_zero(ex_zero), .ex_ALUSrc(s_alusrc), .ex_RegDst(s_regdst), .ex_ALUOp(s_aluop),
        .ex_br_taken(s_br), .mem_MemWrite(s_mw), .mem_MemRead(s_mr),
        .wb_MemtoReg(s_mtr), .wb_RegWrite(s_rw), .wb_dst(s_dst),
        .fwd_a(s_fa), .fwd_b(s_fb), .pc_write(s_pcw), .ifid_write(s_ifw),
        .ifid_flush(s_fl), .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  ex;
        logic [1:0]  mem;
        logic [1:0]  wb;
        logic        br, jmp, zero;
        logic [4:0]  rs, rt, rd;
        logic [2:0]  aluop;
        logic        mr, mw, wrw;
        logic [4:0]  wdst;
        logic [1:0]  fa, fb;
        logic        pcw, ifw, fl, bt;
        logic [15:0] st, fc;
    } vec_t;

    localparam logic [4:0] R = 5'b01010, LW = 5'b10000, ORI = 5'b10011, BEQ = 5'b00001;

    vec_t v[26];
    vec_t nop, lw8, sw5, lw3;
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        id_EX = t.ex; id_MEM = t.mem; id_WB = t.wb; id_branch = t.br; id_jump = t.jmp;
        ex_zero = t.zero; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          ex  mem    wb    br jp z  rs rt rd | op mr mw rw dst fa fb pc if fl bt st fc
        v[0]  = '{LW,  2'b01, 2'b11, 0, 0, 0, 0, 8, 0,   0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0};
        v[1]  = '{R,   2'b00, 2'b01, 0, 0, 0, 8, 8, 9,   0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        v[2]  = '{R,   2'b00, 2'b01, 0, 0, 0, 8, 8, 9,   0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 0};
        v[3]  = '{R,   2'b00, 2'b01, 0, 0, 0, 1, 2, 3,   2, 0, 0, 1, 8,  1, 1, 1, 1, 0, 0, 1, 0};
        v[4]  = '{R,   2'b00, 2'b01, 0, 0, 0, 3, 3, 4,   2, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 0};
        v[5]  = '{R,   2'b00, 2'b01, 0, 0, 0, 1, 2, 6,   2, 0, 0, 1, 9,  2, 2, 1, 1, 0, 0, 1, 0};
        v[6]  = '{R,   2'b00, 2'b01, 0, 0, 0, 4, 4, 7,   2, 0, 0, 1, 3,  0, 0, 1, 1, 0, 0, 1, 0};
        v[7]  = '{ORI, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 4,  1, 1, 1, 1, 0, 0, 1, 0};
        v[8]  = '{R,   2'b00, 2'b01, 0, 0, 0, 0, 0, 2,   3, 0, 0, 1, 6,  0, 0, 1, 1, 0, 0, 1, 0};
        v[9]  = '{R,   2'b00, 2'b01, 0, 0, 0, 2, 2, 2,   2, 0, 0, 1, 7,  0, 0, 1, 1, 0, 0, 1, 0};
        v[10] = '{R,   2'b00, 2'b01, 0, 0, 0, 2, 2, 11,  2, 0, 0, 1, 0,  2, 2, 1, 1, 0, 0, 1, 0};
        v[11] = '{LW,  2'b01, 2'b11, 0, 0, 0, 0, 12, 0,  2, 0, 0, 1, 2,  2, 2, 1, 1, 0, 0, 1, 0};
        v[12] = '{BEQ, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2,  0, 0, 1, 1, 0, 0, 1, 0};
        v[13] = '{R,   2'b00, 2'b01, 0, 0, 1, 12, 12, 13, 1, 1, 0, 1, 11, 0, 0, 1, 1, 1, 1, 1, 0};
        v[14] = '{0,   2'b00, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 12, 0, 0, 1, 1, 0, 0, 1, 1};
        v[15] = '{0,   2'b01, 2'b00, 1, 0, 0, 0, 5, 0,   0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 1};
        v[16] = '{R,   2'b00, 2'b01, 0, 0, 1, 5, 5, 6,   0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 1, 1, 1};
        v[17] = '{0,   2'b00, 2'b00, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 2};
        v[18] = '{0,   2'b00, 2'b00, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 5,  0, 0, 1, 1, 1, 0, 1, 2};
        v[19] = '{0,   2'b00, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 3};
        v[20] = '{0,   2'b00, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 3};
        v[21] = '{0,   2'b00, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 3};
        v[22] = '{LW,  2'b01, 2'b11, 0, 0, 0, 0, 14, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 3};
        v[23] = '{0,   2'b00, 2'b00, 0, 1, 0, 14, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 3};
        v[24] = '{0,   2'b00, 2'b00, 0, 1, 0, 14, 0, 0,  0, 1, 0, 0, 0,  0, 0, 1, 1, 1, 0, 2, 3};
        v[25] = '{0,   2'b00, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 14, 1, 0, 1, 1, 0, 0, 2, 4};
        nop = '0;
        sw5 = '0; sw5.ex = LW; sw5.mem = 2'b10; sw5.rt = 5'd5;
        lw3 = '0; lw3.ex = LW; lw3.mem = 2'b01; lw3.wb = 2'b11; lw3.rt = 5'd3;
        lw8 = lw3; lw8.rs = 5'd8; lw8.rt = 5'd8;

        apply(nop);
        rst = 1'b0;
        step;
        step;
        rst = 1'b1;
        for (int i = 0; i < 26; i++) begin
            apply(v[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                64'({ex_ALUOp, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_dst, fwd_a, fwd_b,
                     pc_write, ifid_write, ifid_flush, ex_br_taken, stall_cnt, flush_cnt}),
                64'({v[i].aluop, v[i].mr, v[i].mw, v[i].wrw, v[i].wdst, v[i].fa, v[i].fb,
                     v[i].pcw, v[i].ifw, v[i].fl, v[i].bt, v[i].st, v[i].fc}));
            step;
        end

        apply(sw5);
        step;
        apply(nop);
        step;
        @(negedge clk);
        chk("sw_in_exmem", 64'({mem_MemWrite, stall_cnt, flush_cnt}), 64'({1'b1, 16'd2, 16'd4}));
        rst = 1'b0;
        apply(lw3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(nop);
        ex_zero = 1'b1;
        @(negedge clk);
        chk("rst_state", 64'({mem_MemWrite, mem_MemRead, wb_RegWrite, wb_dst, ex_ALUOp, stall_cnt, flush_cnt}), 64'd0);
        chk("rst_ctl", 64'({fwd_a, fwd_b, pc_write, ifid_write, ifid_flush, ex_br_taken}), 64'h0C);
        chk("rst_small_cnt", 64'({s_stall, s_flush}), 64'd0);

        apply(lw8);
        repeat (31) step;
        @(negedge clk);
        chk("stall15_main", 64'(stall_cnt), 64'd15);
        chk("stall15_small", 64'(s_stall), 64'd15);
        repeat (8) step;
        @(negedge clk);
        chk("stall_sat_small", 64'(s_stall), 64'd15);
        chk("stall19_main", 64'(stall_cnt), 64'd19);
        chk("flush_idle", 64'({flush_cnt, s_flush}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
